// File: rtl/hold_2_fsm.sv
// Autonomous four-state Moore sequencer: o_g strobes on every change of the held level o_f.
// Outputs are registered and take the value belonging to the state being entered.
module hold_2_fsm #(
  parameter int HOLD_CYC = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_g,
  output logic       o_f,
  output logic [1:0] o_state,
  output logic [3:0] o_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SET  = 2'd1,
    S_HOLD = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(HOLD_CYC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_g;
  logic       r_f;

  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_next_g;
  logic       w_next_f;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_g     <= 1'b0;
      r_f     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_g     <= w_next_g;
      r_f     <= w_next_f;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    w_next_cnt   = r_cnt;
    w_next_g     = 1'b0;
    w_next_f     = r_f;

    case (r_state)
      S_IDLE: w_next_state = S_SET;
      S_SET: begin
        w_next_state = S_HOLD;
        w_next_cnt   = 4'd0;
      end
      S_HOLD: begin
        if (r_cnt == LP_LAST) begin
          w_next_state = S_CLR;
        end else begin
          w_next_state = S_HOLD;
          w_next_cnt   = r_cnt + 4'd1;
        end
      end
      S_CLR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    // Outputs follow the state being entered so they change on the same edge.
    case (w_next_state)
      S_SET: begin
        w_next_g = 1'b1;
        w_next_f = 1'b1;
      end
      S_CLR: begin
        w_next_g = 1'b1;
        w_next_f = 1'b0;
      end
      S_IDLE, S_HOLD: begin
        w_next_g = 1'b0;
        w_next_f = r_f;
      end
      default: begin
        w_next_g = 1'b0;
        w_next_f = 1'b0;
      end
    endcase
  end

  assign o_g     = r_g;
  assign o_f     = r_f;
  assign o_state = r_state;
  assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_hold_2_fsm.sv
// Directed bench for hold_2_fsm: three instances (HOLD_CYC 3, 1, 15) share clock and reset.
// Outputs are driven and sampled on the falling clock edge.
module tb_hold_2_fsm;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       g3, f3, g1, f1, g15, f15;
  logic [1:0] st3, st1, st15;
  logic [3:0] cnt3, cnt1, cnt15;

  hold_2_fsm #(.HOLD_CYC(3)) u_hc3 (
    .i_clk(clk), .i_rst_n(rst_n), .o_g(g3), .o_f(f3), .o_state(st3), .o_cnt(cnt3)
  );
  hold_2_fsm #(.HOLD_CYC(1)) u_hc1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_g(g1), .o_f(f1), .o_state(st1), .o_cnt(cnt1)
  );
  hold_2_fsm #(.HOLD_CYC(15)) u_hc15 (
    .i_clk(clk), .i_rst_n(rst_n), .o_g(g15), .o_f(f15), .o_state(st15), .o_cnt(cnt15)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Checks one instance against an expected g/f/state triple.
  task automatic check_gfs(input string tag, input logic g, input logic f, input logic [1:0] st,
                           input logic eg, input logic ef, input logic [1:0] est);
    check({tag, "_g"}, {7'd0, g}, {7'd0, eg});
    check({tag, "_f"}, {7'd0, f}, {7'd0, ef});
    check({tag, "_st"}, {6'd0, st}, {6'd0, est});
  endtask

  // Hand-derived expectations after edges E0..E18 (bit k = value after Ek).
  logic [18:0] exp_g3  = 19'b101_0001_0100_0101_0001;
  logic [18:0] exp_f3  = 19'b100_1111_0011_1100_1111;
  logic [18:0] exp_g1  = 19'b101_0101_0101_0101_0101;
  logic [18:0] exp_f1  = 19'b011_0011_0011_0011_0011;
  logic [18:0] exp_g15 = 19'b101_0000_0000_0000_0001;
  logic [18:0] exp_f15 = 19'b100_1111_1111_1111_1111;
  logic [1:0]  exp_st3 [0:5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};

  logic prev_g3, prev_f3;

  initial begin
    // Reset held for two rising edges, released at 20 ns.
    rst_n = 1'b0;
    tick();
    check("rst1_g3", {7'd0, g3}, 8'd0);
    check("rst1_f3", {7'd0, f3}, 8'd0);
    tick();
    check_gfs("rst2_hc3", g3, f3, st3, 1'b0, 1'b0, 2'd0);
    check_gfs("rst2_hc1", g1, f1, st1, 1'b0, 1'b0, 2'd0);
    check_gfs("rst2_hc15", g15, f15, st15, 1'b0, 1'b0, 2'd0);
    check("rst2_cnt3", {4'd0, cnt3}, 8'd0);
    rst_n = 1'b1;

    // Free-running sequence E0..E18 on all three instances.
    prev_g3 = 1'b0;
    prev_f3 = 1'b0;
    for (int k = 0; k < 19; k++) begin
      tick();
      check($sformatf("seq_hc3_g_E%0d", k), {7'd0, g3}, {7'd0, exp_g3[k]});
      check($sformatf("seq_hc3_f_E%0d", k), {7'd0, f3}, {7'd0, exp_f3[k]});
      check($sformatf("seq_hc3_st_E%0d", k), {6'd0, st3}, {6'd0, exp_st3[k % 6]});
      check($sformatf("seq_hc1_g_E%0d", k), {7'd0, g1}, {7'd0, exp_g1[k]});
      check($sformatf("seq_hc1_f_E%0d", k), {7'd0, f1}, {7'd0, exp_f1[k]});
      check($sformatf("seq_hc15_g_E%0d", k), {7'd0, g15}, {7'd0, exp_g15[k]});
      check($sformatf("seq_hc15_f_E%0d", k), {7'd0, f15}, {7'd0, exp_f15[k]});
      check($sformatf("hold_f_only_with_g_E%0d", k), {7'd0, (f3 !== prev_f3) && !g3}, 8'd0);
      check($sformatf("no_double_g_E%0d", k), {7'd0, prev_g3 && g3}, 8'd0);
      if (k >= 1 && k <= 3) check($sformatf("seq_hc3_cnt_E%0d", k), {4'd0, cnt3}, 8'(k - 1));
      if (k == 15) check("seq_hc15_cnt_E15", {4'd0, cnt15}, 8'd14);
      if (k == 17) check("seq_hc15_cnt_E17", {4'd0, cnt15}, 8'd14);
      prev_g3 = g3;
      prev_f3 = f3;
    end

    // hc3 sits in SET after E18: reset there, and keep it low a second edge.
    rst_n = 1'b0;
    tick();
    check_gfs("rst_in_set_hc3", g3, f3, st3, 1'b0, 1'b0, 2'd0);
    check_gfs("rst_in_clr_hc1", g1, f1, st1, 1'b0, 1'b0, 2'd0);
    check_gfs("rst_in_set_hc15", g15, f15, st15, 1'b0, 1'b0, 2'd0);
    tick();
    check("rst_hold_no_g3", {7'd0, g3}, 8'd0);
    rst_n = 1'b1;

    // Mid-HOLD reset: run E0..E2, assert reset for the following edge.
    tick();
    check_gfs("mid_E0_hc3", g3, f3, st3, 1'b1, 1'b1, 2'd1);
    tick();
    tick();
    check_gfs("mid_E2_hc3", g3, f3, st3, 1'b0, 1'b1, 2'd2);
    check("mid_E2_cnt3", {4'd0, cnt3}, 8'd1);
    check_gfs("mid_E2_hc1", g1, f1, st1, 1'b1, 1'b0, 2'd3);
    rst_n = 1'b0;
    tick();
    check_gfs("mid_rst_hc3", g3, f3, st3, 1'b0, 1'b0, 2'd0);
    check("mid_rst_cnt3", {4'd0, cnt3}, 8'd0);
    check_gfs("mid_rst_hc15", g15, f15, st15, 1'b0, 1'b0, 2'd0);
    check("mid_rst_cnt15", {4'd0, cnt15}, 8'd0);
    rst_n = 1'b1;
    tick();
    check_gfs("mid_rel_hc3", g3, f3, st3, 1'b1, 1'b1, 2'd1);
    check_gfs("mid_rel_hc1", g1, f1, st1, 1'b1, 1'b1, 2'd1);

    // Reset while in SET: f must drop rather than carry into HOLD.
    rst_n = 1'b0;
    tick();
    check_gfs("set_rst_hc3", g3, f3, st3, 1'b0, 1'b0, 2'd0);
    check_gfs("set_rst_hc15", g15, f15, st15, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    // Run hc3 into CLR (E4) then reset: no extra strobe on the following edges.
    for (int k = 0; k < 5; k++) tick();
    check_gfs("clr_E4_hc3", g3, f3, st3, 1'b1, 1'b0, 2'd3);
    rst_n = 1'b0;
    tick();
    check_gfs("clr_rst_hc3", g3, f3, st3, 1'b0, 1'b0, 2'd0);
    tick();
    check("clr_rst2_g3", {7'd0, g3}, 8'd0);
    rst_n = 1'b1;
    tick();
    check_gfs("clr_rel_hc3", g3, f3, st3, 1'b1, 1'b1, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
